// File: rtl/bcd_countdown_timer_pkg.sv
// rtl/bcd_countdown_timer_pkg.sv - shared types and constants for the BCD countdown timer
package bcd_countdown_timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_ZERO = 4'd0;

    function automatic logic [3:0] clamp_bcd(input logic [3:0] nibble);
        return (nibble > BCD_MAX) ? BCD_MAX : nibble;
    endfunction

endpackage

// File: rtl/bcd_countdown_timer_digit.sv
// rtl/bcd_countdown_timer_digit.sv - one BCD down-counting digit with borrow chain
module bcd_down_digit
    import bcd_countdown_timer_pkg::*;
(
    input  logic       in_clk,
    input  logic       in_reset_n,
    input  logic       borrow_in,
    input  logic       load,
    input  logic [3:0] load_value,
    output logic [3:0] digit,
    output logic       is_zero,
    output logic       borrow_out
);

    assign is_zero    = (digit == BCD_ZERO);
    assign borrow_out = borrow_in & is_zero;

    always_ff @(posedge in_clk or negedge in_reset_n) begin
        if (!in_reset_n) begin
            digit <= BCD_ZERO;
        end else if (load) begin
            digit <= load_value;
        end else if (borrow_in) begin
            digit <= is_zero ? BCD_MAX : digit - 4'd1;
        end
    end

endmodule

// File: rtl/bcd_countdown_timer.sv
// rtl/bcd_countdown_timer.sv - multi-digit BCD countdown timer with load/start/stop and expiry pulse
module bcd_countdown_timer
    import bcd_countdown_timer_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic                in_clk,
    input  logic                in_reset_n,
    input  logic                in_tick,
    input  logic                in_load,
    input  logic [4*DIGITS-1:0] in_load_value,
    input  logic                in_start,
    input  logic                in_stop,
    output logic [4*DIGITS-1:0] out_count,
    output logic                out_running,
    output logic                out_expired,
    output logic                out_zero
);

    localparam int CW = 4 * DIGITS;

    state_t          state_q, state_d;
    logic [CW-1:0]   reload_q;
    logic [CW-1:0]   load_clamped;
    logic [CW-1:0]   digit_load_value;
    logic [DIGITS:0] borrow;
    logic [DIGITS-1:0] digit_zero;
    logic            dec_en;
    logic            will_expire;
    logic            reload_now;
    logic            digit_load;
    logic            expired_q;
    logic            unused_borrow;

    // Load, stop and a zero count all suppress the decrement for this cycle
    assign dec_en      = (state_q == RUN) & in_tick & ~in_load & ~in_stop & ~out_zero;
    assign will_expire = dec_en & (out_count == CW'(1));
    assign reload_now  = will_expire & AUTO_RELOAD & (reload_q != '0);
    assign digit_load  = in_load | reload_now;
    assign digit_load_value = in_load ? load_clamped : reload_q;

    assign borrow[0]     = dec_en;
    assign unused_borrow = borrow[DIGITS];

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        assign load_clamped[4*i +: 4] = clamp_bcd(in_load_value[4*i +: 4]);

        bcd_down_digit u_digit (
            .in_clk     (in_clk),
            .in_reset_n (in_reset_n),
            .borrow_in  (borrow[i]),
            .load       (digit_load),
            .load_value (digit_load_value[4*i +: 4]),
            .digit      (out_count[4*i +: 4]),
            .is_zero    (digit_zero[i]),
            .borrow_out (borrow[i+1])
        );
    end

    assign out_zero    = &digit_zero;
    assign out_running = (state_q == RUN);
    assign out_expired = expired_q;

    always_comb begin
        state_d = state_q;
        if (in_load) begin
            state_d = PAUSE;
        end else begin
            case (state_q)
                PAUSE: if (in_start && !out_zero) state_d = RUN;
                RUN: begin
                    if (in_stop) begin
                        state_d = PAUSE;
                    end else if (will_expire && !reload_now) begin
                        state_d = DONE;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge in_clk or negedge in_reset_n) begin
        if (!in_reset_n) begin
            state_q   <= IDLE;
            reload_q  <= '0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            expired_q <= will_expire;
            if (in_load) begin
                reload_q <= load_clamped;
            end
        end
    end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// tb/tb_bcd_countdown_timer.sv - directed self-checking bench for bcd_countdown_timer
module tb_bcd_countdown_timer;

    logic        in_clk = 1'b0;
    logic        in_reset_n;
    logic        in_tick, in_load, in_start, in_stop;
    logic [15:0] in_load_value;
    logic [15:0] cnt0, cnt1;
    logic        run0, run1, exp0, exp1, zero0, zero1;

    int tests_run = 0;
    int tests_failed = 0;

    logic [15:0] seq12 [12] = '{16'h0011, 16'h0010, 16'h0009, 16'h0008, 16'h0007, 16'h0006,
                                16'h0005, 16'h0004, 16'h0003, 16'h0002, 16'h0001, 16'h0000};
    logic [15:0] seq_ar [9] = '{16'h0002, 16'h0001, 16'h0003, 16'h0002, 16'h0001, 16'h0003,
                                16'h0002, 16'h0001, 16'h0003};

    always #5 in_clk = ~in_clk;

    bcd_countdown_timer #(.DIGITS(4), .AUTO_RELOAD(1'b0)) dut (
        .in_clk(in_clk), .in_reset_n(in_reset_n), .in_tick(in_tick), .in_load(in_load),
        .in_load_value(in_load_value), .in_start(in_start), .in_stop(in_stop),
        .out_count(cnt0), .out_running(run0), .out_expired(exp0), .out_zero(zero0)
    );

    bcd_countdown_timer #(.DIGITS(4), .AUTO_RELOAD(1'b1)) dut_ar (
        .in_clk(in_clk), .in_reset_n(in_reset_n), .in_tick(in_tick), .in_load(in_load),
        .in_load_value(in_load_value), .in_start(in_start), .in_stop(in_stop),
        .out_count(cnt1), .out_running(run1), .out_expired(exp1), .out_zero(zero1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step(input logic ld, input logic [15:0] v, input logic st,
                        input logic sp, input logic tk);
        in_load = ld; in_load_value = v; in_start = st; in_stop = sp; in_tick = tk;
        @(posedge in_clk);
        #1;
        in_load = 1'b0; in_start = 1'b0; in_stop = 1'b0; in_tick = 1'b0;
    endtask

    initial begin
        in_reset_n = 1'b0;
        in_tick = 1'b0; in_load = 1'b0; in_start = 1'b0; in_stop = 1'b0;
        in_load_value = 16'h0000;
        repeat (2) @(posedge in_clk);
        #1;
        in_reset_n = 1'b1;
        chk("reset_count", cnt0, 16'h0000);
        chk("reset_running", run0, 1'b0);
        chk("reset_expired", exp0, 1'b0);
        chk("reset_zero", zero0, 1'b1);

        step(0, 16'h0000, 1, 0, 0);
        chk("idle_start_ignored", run0, 1'b0);

        step(1, 16'h0012, 0, 0, 0);
        chk("load12_count", cnt0, 16'h0012);
        chk("load12_paused", run0, 1'b0);
        step(0, 16'h0000, 1, 0, 0);
        chk("start12_running", run0, 1'b1);
        for (int i = 0; i < 12; i++) begin
            step(0, 16'h0000, 0, 0, 1);
            chk($sformatf("count12_tick%0d", i), cnt0, seq12[i]);
            chk($sformatf("expired12_tick%0d", i), exp0, (i == 11) ? 1'b1 : 1'b0);
        end
        chk("done_running", run0, 1'b0);
        chk("done_zero", zero0, 1'b1);
        step(0, 16'h0000, 0, 0, 1);
        chk("done_expired_cleared", exp0, 1'b0);
        chk("done_holds_zero", cnt0, 16'h0000);
        step(0, 16'h0000, 1, 0, 0);
        chk("done_start_ignored", run0, 1'b0);

        step(1, 16'h1000, 0, 0, 0);
        step(0, 16'h0000, 1, 0, 0);
        step(0, 16'h0000, 0, 0, 1);
        chk("borrow_chain", cnt0, 16'h0999);

        step(1, 16'h0005, 0, 0, 0);
        step(0, 16'h0000, 1, 0, 0);
        step(0, 16'h0000, 0, 0, 1);
        step(0, 16'h0000, 0, 0, 1);
        chk("pause_pre_stop", cnt0, 16'h0003);
        step(0, 16'h0000, 0, 1, 0);
        chk("stop_running", run0, 1'b0);
        for (int i = 0; i < 3; i++) step(0, 16'h0000, 0, 0, 1);
        chk("pause_holds", cnt0, 16'h0003);
        chk("pause_not_running", run0, 1'b0);
        step(0, 16'h0000, 1, 0, 0);
        step(0, 16'h0000, 0, 0, 1);
        chk("resume_tick1", cnt0, 16'h0002);
        step(0, 16'h0000, 0, 0, 1);
        chk("resume_tick2_noexp", exp0, 1'b0);
        step(0, 16'h0000, 0, 0, 1);
        chk("resume_final_count", cnt0, 16'h0000);
        chk("resume_final_expired", exp0, 1'b1);

        step(1, 16'h0003, 0, 0, 0);
        step(0, 16'h0000, 1, 0, 0);
        for (int i = 0; i < 9; i++) begin
            step(0, 16'h0000, 0, 0, 1);
            chk($sformatf("ar_count_%0d", i), cnt1, seq_ar[i]);
            chk($sformatf("ar_expired_%0d", i), exp1, (i % 3 == 2) ? 1'b1 : 1'b0);
            chk($sformatf("ar_running_%0d", i), run1, 1'b1);
        end

        step(1, 16'h00AF, 0, 0, 0);
        chk("clamp_count", cnt0, 16'h0099);
        step(1, 16'h0000, 0, 0, 0);
        step(0, 16'h0000, 1, 0, 0);
        chk("zero_start_running", run0, 1'b0);
        chk("zero_start_expired", exp0, 1'b0);

        step(1, 16'h0005, 0, 0, 0);
        step(0, 16'h0000, 1, 0, 1);
        chk("start_tick_running", run0, 1'b1);
        chk("start_tick_nodec", cnt0, 16'h0005);
        step(1, 16'h0042, 0, 0, 1);
        chk("load_mid_run_count", cnt0, 16'h0042);
        chk("load_mid_run_paused", run0, 1'b0);

        step(1, 16'h0050, 0, 0, 0);
        step(0, 16'h0000, 1, 0, 0);
        step(0, 16'h0000, 0, 0, 1);
        chk("pre_reset_count", cnt0, 16'h0049);
        #2;
        in_reset_n = 1'b0;
        #1;
        chk("async_reset_count", cnt0, 16'h0000);
        chk("async_reset_running", run0, 1'b0);
        chk("async_reset_zero", zero0, 1'b1);
        @(negedge in_clk);
        in_reset_n = 1'b1;
        step(0, 16'h0000, 1, 0, 0);
        chk("post_reset_idle", run0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
